maxpool2d_stream: RTL

// - 2x2, stride-2 max-pooling stage directly downstream of the conv2d core; consumes its pxl_ena_z/pxl_z

---
 rtl/cnn_pkg.sv | 28 ++
 rtl/maxpool2d_stream_if.sv | 38 +++
 rtl/fp32_max.sv | 20 ++
 rtl/maxpool2d_stream.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cnn_pkg
// Purpose  : Shared fp32 definitions for the CNN datapath stages.
//            FP32_W / FP_SIGN_BIT describe the IEEE-754 single format.
//            fp32_key maps an fp32 bit pattern onto an unsigned key. Comparing
//            two keys as unsigned numbers orders the two floats.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package cnn_pkg;

  localparam int FP32_W      = 32;
  localparam int FP_SIGN_BIT = 31;

  typedef logic [FP32_W-1:0] fp32_t;

  localparam fp32_t FP_POS_ZERO = 32'h0000_0000;

  // Negative values are bit-inverted, so a larger magnitude gives a smaller key.
  // Positive values get their sign bit set, which places them above every
  // negative value. -0 maps to 7FFF_FFFF and +0 maps to 8000_0000, so -0 < +0.
  function automatic fp32_t fp32_key(input fp32_t x);
    return x[FP_SIGN_BIT] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage
`default_nettype wire

// File: rtl/maxpool2d_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2d_stream_if
// Purpose  : Parameter load and pixel stream bundle of the max-pool stage.
//            master : upstream side. Drives the params and the input pixels.
//                     Receives the pooled stream.
//            slave  : the pooling stage itself.
// Signals  : param_ena, param_width, param_height, pxl_ena_x, pxl_x   (in)
//            pxl_ena_y, pxl_y, frame_done                            (out)
// Revision : 1.0  initial release
// ============================================================================
interface maxpool2d_stream_if
  import cnn_pkg::*;
#(
  parameter int C_WIDTH = 9
) ();

  logic               param_ena;
  logic [C_WIDTH-1:0] param_width;
  logic [C_WIDTH-1:0] param_height;
  logic               pxl_ena_x;
  fp32_t              pxl_x;
  logic               pxl_ena_y;
  fp32_t              pxl_y;
  logic               frame_done;

  modport master (
    output param_ena, param_width, param_height, pxl_ena_x, pxl_x,
    input  pxl_ena_y, pxl_y, frame_done
  );

  modport slave (
    input  param_ena, param_width, param_height, pxl_ena_x, pxl_x,
    output pxl_ena_y, pxl_y, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/fp32_max.sv
`default_nettype none
// ============================================================================
// Module   : fp32_max
// Purpose  : Combinational two-input fp32 maximum, decided on ordering keys.
//            A tie returns i_a. Callers connect the earlier operand to i_a.
// Ports    : i_a, i_b (fp32 in), o_max (fp32 out)
// Revision : 1.0  initial release
// ============================================================================
module fp32_max
  import cnn_pkg::*;
(
  input  wire fp32_t i_a,
  input  wire fp32_t i_b,
  output fp32_t      o_max
);

  assign o_max = (fp32_key(i_b) > fp32_key(i_a)) ? i_b : i_a;

endmodule
`default_nettype wire

// File: rtl/maxpool2d_stream.sv
`default_nettype none
// ============================================================================
// Module   : maxpool2d_stream
// Purpose  : 2x2 / stride-2 fp32 max-pool stage on a raster pixel stream.
//            Each horizontal pair maximum of an even row is kept in a
//            one-row line buffer. On the odd row it is merged with the
//            matching pair maximum below it. The pooled pixel appears two
//            cycles after the odd-row/odd-column input pixel.
// Ports    : clk, rst        clock and asynchronous active-high reset
//            bus (slave)     param_ena/width/height, pxl_ena_x/pxl_x in,
//                            pxl_ena_y/pxl_y/frame_done out
// Config   : MAXPOOL_RELU_EN  when defined, a negative pooled result is
//                             replaced by +0 (fused ReLU).
// Revision : 1.0  initial release
// ============================================================================
module maxpool2d_stream
  import cnn_pkg::*;
#(
  parameter int C_WIDTH  = 9,
  parameter int LB_DEPTH = 256
) (
  input wire logic          clk,
  input wire logic          rst,
  maxpool2d_stream_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int             AW    = C_WIDTH - 1;
  localparam logic [C_WIDTH:0] C_ONE = (C_WIDTH + 1)'(1);

  logic [1:0]         r_state, w_state_nxt;
  logic               w_run, w_accept;
  logic [C_WIDTH-1:0] r_width, r_height, r_col, r_row;
  logic [C_WIDTH:0]   w_col_inc, w_row_inc;
  logic               w_col_last, w_frame_last;
  logic [AW-1:0]      w_addr;
  logic               w_pair_even_row, w_pair_odd_row;

  fp32_t r_prev, r_pm, r_lb_rd, r_y;
  fp32_t w_pm, w_vm, w_res;
  logic  r_v1, r_last1, r_ena_y, r_done;
  fp32_t r_lb [LB_DEPTH];

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // RUN is left one cycle after the last input pixel. By then that pixel's
  // pooled result is in the output stage, so it still comes out. A
  // param_ena in that cycle counts as an abort and suppresses it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.param_ena) w_state_nxt = S_RUN;
      S_RUN:   if (bus.param_ena) w_state_nxt = S_RUN;
               else if (r_last1)  w_state_nxt = S_DONE;
      S_DONE:  if (bus.param_ena) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // No pixel is accepted in the cycle after the frame's last pixel, while
  // the FSM is still in RUN.
  always_comb begin
    w_run    = (r_state == S_RUN);
    w_accept = w_run && bus.pxl_ena_x && !bus.param_ena && !r_last1;
  end

  // ----------------------------------------------------------- counters ----
  // Use >= on extended values so that a zero width or height still ends a
  // row or frame.
  assign w_col_inc    = {1'b0, r_col} + C_ONE;
  assign w_row_inc    = {1'b0, r_row} + C_ONE;
  assign w_col_last   = (w_col_inc >= {1'b0, r_width});
  assign w_frame_last = w_col_last && (w_row_inc >= {1'b0, r_height});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width  <= '0;
      r_height <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else if (bus.param_ena) begin
      r_width  <= bus.param_width;
      r_height <= bus.param_height;
      r_col    <= '0;
      r_row    <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_inc[C_WIDTH-1:0];
      end else begin
        r_col <= w_col_inc[C_WIDTH-1:0];
      end
    end
  end

  // ------------------------------------------------- pair max / stage 1 ----
  fp32_max u_hmax (.i_a(r_prev), .i_b(bus.pxl_x), .o_max(w_pm));

  assign w_addr          = r_col[C_WIDTH-1:1];
  assign w_pair_even_row = w_accept && r_col[0] && !r_row[0];
  assign w_pair_odd_row  = w_accept && r_col[0] &&  r_row[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_pm    <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      r_v1    <= w_pair_odd_row;
      r_last1 <= w_accept && w_frame_last;
      if (w_accept && !r_col[0]) r_prev <= bus.pxl_x;
      if (w_pair_odd_row)        r_pm   <= w_pm;
    end
  end

  // Even rows only write and odd rows only read, so a read never collides
  // with a write to the same word.
  always_ff @(posedge clk) begin
    if (w_pair_even_row) r_lb[w_addr] <= w_pm;
    if (w_pair_odd_row)  r_lb_rd      <= r_lb[w_addr];
  end

  // ------------------------------------------- vertical merge / stage 2 ----
  fp32_max u_vmax (.i_a(r_lb_rd), .i_b(r_pm), .o_max(w_vm));

`ifdef MAXPOOL_RELU_EN
  assign w_res = w_vm[FP_SIGN_BIT] ? FP_POS_ZERO : w_vm;
`else
  assign w_res = w_vm;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ena_y <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
    end else begin
      r_ena_y <= r_v1 && !bus.param_ena;
      r_done  <= r_last1 && !bus.param_ena;
      if (r_v1 && !bus.param_ena) r_y <= w_res;
    end
  end

  assign bus.pxl_ena_y  = r_ena_y;
  assign bus.pxl_y      = r_y;
  assign bus.frame_done = r_done;

endmodule
`default_nettype wire
